// File: rtl/tqvp_vibhee_fir_pkg.sv
// Shared constants and types for the FIR result drain path.
// Sample/byte widths, byte_sel encoding and default FIFO depth.
package tqvp_vibhee_fir_pkg;

  localparam int SAMPLE_W      = 16;
  localparam int BYTE_W        = 8;
  localparam int FIR_RES_DEPTH = 4;

  typedef enum logic {
    BSEL_LO = 1'b0,
    BSEL_HI = 1'b1
  } bsel_e;

endpackage

// File: rtl/tqvp_vibhee_sync_fifo.sv
// Generic synchronous FIFO with wrapping pointers and level count.
// A push into a full FIFO is accepted only when a pop completes alongside it.
module tqvp_vibhee_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/tqvp_vibhee_fir_result_reader.sv
// FIR result drain: captures samples into a FIFO and hands them
// to the byte-wide register bus low byte first, with sticky overflow.
module tqvp_vibhee_fir_result_reader
  import tqvp_vibhee_fir_pkg::*;
#(
  parameter int DEPTH  = FIR_RES_DEPTH,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  input  logic                     rd_ack,
  input  logic                     clr_ovf,
  output logic [BYTE_W-1:0]        rd_byte,
  output logic                     byte_sel,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  bsel_e             r_bsel;
  logic              r_ovf;
  logic [DATA_W-1:0] w_head;
  logic              w_pop;
  logic              w_drop;

  // Only the high-byte ack retires an entry.
  assign w_pop  = rd_ack && (r_bsel == BSEL_HI) && !empty;
  assign w_drop = in_valid && full && !w_pop;

  tqvp_vibhee_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_pop   (w_pop),
    .i_wdata (in_data),
    .o_rdata (w_head),
    .o_level (level),
    .o_empty (empty),
    .o_full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bsel <= BSEL_LO;
    end else begin
      unique case (r_bsel)
        BSEL_LO: if (rd_ack && !empty) r_bsel <= BSEL_HI;
        BSEL_HI: if (rd_ack)           r_bsel <= BSEL_LO;
        default:                       r_bsel <= BSEL_LO;
      endcase
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  always_comb begin
    rd_byte = '0;
    if (!empty) begin
      if (r_bsel == BSEL_HI) rd_byte = w_head[2*BYTE_W-1:BYTE_W];
      else                   rd_byte = w_head[BYTE_W-1:0];
    end
  end

  assign byte_sel = r_bsel;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_tqvp_vibhee_fir_result_reader.sv
// Bench for the FIR result reader: directed plan steps plus a random
// phase, all checked against a queue-based model of the drain path.
module tb_tqvp_vibhee_fir_result_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        rd_ack;
  logic        clr_ovf;
  logic [7:0]  rd_byte;
  logic        byte_sel;
  logic [2:0]  level;
  logic        empty;
  logic        full;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] q[$];
  bit          m_hi;
  bit          m_ovf;

  always #5 clk = ~clk;

  tqvp_vibhee_fir_result_reader dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .rd_ack   (rd_ack),
    .clr_ovf  (clr_ovf),
    .rd_byte  (rd_byte),
    .byte_sel (byte_sel),
    .level    (level),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [7:0] eb;
    eb = 8'h00;
    if (q.size() != 0) eb = m_hi ? q[0][15:8] : q[0][7:0];
    chk({tag, ".rd_byte"},  32'(rd_byte),  32'(eb));
    chk({tag, ".byte_sel"}, 32'(byte_sel), 32'(m_hi));
    chk({tag, ".level"},    32'(level),    32'(q.size()));
    chk({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
    chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  // Behavioural model: ack sequencing first, then accept or drop the sample.
  task automatic model(input bit v, input logic [15:0] d,
                       input bit ack, input bit clr);
    bit popped, dropped;
    popped  = 0;
    dropped = 0;
    if (ack && q.size() != 0) begin
      if (!m_hi) m_hi = 1;
      else begin
        void'(q.pop_front());
        m_hi   = 0;
        popped = 1;
      end
    end
    if (v) begin
      if (q.size() < DEPTH) q.push_back(d);
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic step(input bit v, input logic [15:0] d,
                      input bit ack, input bit clr, input string tag);
    in_valid = v;
    in_data  = d;
    rd_ack   = ack;
    clr_ovf  = clr;
    @(posedge clk);
    #1;
    in_valid = 0;
    rd_ack   = 0;
    clr_ovf  = 0;
    model(v, d, ack, clr);
    chk_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_hi  = 0;
    m_ovf = 0;
  endtask

  initial begin
    rst = 1; in_data = '0; in_valid = 0; rd_ack = 0; clr_ovf = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_all("reset");
    step(0, 16'h0, 0, 0, "idle");

    step(1, 16'hA51C, 0, 0, "push_a51c");
    chk("a51c.lo", 32'(rd_byte), 32'h1C);
    step(0, 16'h0, 1, 0, "ack1");
    chk("a51c.hi", 32'(rd_byte), 32'hA5);
    chk("a51c.sel", 32'(byte_sel), 32'd1);
    step(0, 16'h0, 1, 0, "ack2");
    chk("a51c.empty", 32'(empty), 32'd1);

    for (int i = 1; i <= 4; i++) step(1, 16'(i), 0, 0, "fill");
    chk("fill.level", 32'(level), 32'd4);
    chk("fill.full", 32'(full), 32'd1);
    step(1, 16'h0005, 0, 0, "drop5");
    chk("drop5.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] eb;
      eb = (i % 2 == 0) ? 8'(i / 2 + 1) : 8'h00;
      chk("drain.byte", 32'(rd_byte), 32'(eb));
      step(0, 16'h0, 1, 0, "drain");
    end
    chk("drain.empty", 32'(empty), 32'd1);

    for (int i = 1; i <= 4; i++) step(1, 16'(i), 0, 0, "refill");
    step(1, 16'h0077, 0, 1, "clr_and_drop");
    chk("clr_drop.ovf", 32'(overflow), 32'd1);
    step(0, 16'h0, 0, 1, "clr_alone");
    chk("clr.ovf", 32'(overflow), 32'd0);

    step(0, 16'h0, 1, 0, "full_ack1");
    step(1, 16'h1234, 1, 0, "full_pushpop");
    chk("pushpop.level", 32'(level), 32'd4);
    chk("pushpop.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 16'h0, 1, 0, "drain2");
    chk("last.lo", 32'(rd_byte), 32'h34);
    step(0, 16'h0, 1, 0, "last_ack1");
    chk("last.hi", 32'(rd_byte), 32'h12);
    step(0, 16'h0, 1, 0, "last_ack2");

    step(0, 16'h0, 1, 0, "ack_empty");
    chk("ack_empty.sel", 32'(byte_sel), 32'd0);
    step(1, 16'h00FF, 1, 0, "push_ack_empty");
    chk("pae.level", 32'(level), 32'd1);
    chk("pae.byte", 32'(rd_byte), 32'hFF);
    chk("pae.sel", 32'(byte_sel), 32'd0);

    step(0, 16'h0, 1, 0, "pre_rst_hi");
    rst = 1;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1 rst = 0;
    chk_all("post_rst");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) < 50, 16'($urandom),
           $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 10, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
